// File: rtl/nes_fb_dbuf_if.sv
// ----------------------------------------------------------------------------
// nes_fb_dbuf_if
//   Bus bundle between the NES double-buffered framebuffer and its clients
//   (PPU write side, display read side, swap handshake, clear control).
//
//   Parameters:
//     ADDR_W  linear pixel address width
//     PIX_W   bits per pixel (palette index)
//
//   Modports:
//     master  client side: drives strobes, addresses, data and requests
//     slave   framebuffer side: drives read data and status
// ----------------------------------------------------------------------------
interface nes_fb_dbuf_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 6
);
    // Display read port
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;

    // PPU write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    // Frame-complete / swap handshake
    logic              frame_done;
    logic              swap_req;
    logic              swapped;
    logic              overrun;
    logic              pending;
    logic              front_bank;

    // Back-bank clear control
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
               frame_done, swap_req, clr_req,
        input  rd_data, rd_valid, swapped, overrun, pending,
               front_bank, clr_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
               frame_done, swap_req, clr_req,
        output rd_data, rd_valid, swapped, overrun, pending,
               front_bank, clr_busy
    );
endinterface

// File: rtl/nes_fb_dbuf.sv
// ----------------------------------------------------------------------------
// nes_fb_dbuf
//   Double-buffered NES framebuffer, single clock domain. The PPU writes the
//   back bank while the display scans the front bank. Banks are exchanged
//   only when the display asks (swap_req, at vblank) and a completed frame is
//   waiting, so the display never shows a torn frame.
//
//   Optional feature: define NES_FB_CLEAR_EN to build the back-bank clear
//   engine (fills the back bank with CLEAR_VAL). Without it clr_req is
//   ignored, clr_busy is 0 and swaps are never deferred.
//
//   Ports:
//     clk   system / PPU clock
//     rst   synchronous active-high reset
//     bus   nes_fb_dbuf_if.slave
//           rd_en/rd_addr -> rd_data/rd_valid   (1-cycle latency, front bank)
//           wr_en/wr_addr/wr_data               (back bank)
//           frame_done, swap_req -> swapped, overrun, pending, front_bank
//           clr_req -> clr_busy
// ----------------------------------------------------------------------------
module nes_fb_dbuf #(
    parameter int                WIDTH     = 256,
    parameter int                HEIGHT    = 240,
    parameter int                PIX_W     = 6,
    parameter int                ADDR_W    = 16,
    parameter logic [PIX_W-1:0]  CLEAR_VAL = 6'h0F
) (
    input  logic          clk,
    input  logic          rst,
    nes_fb_dbuf_if.slave  bus
);

    localparam int DEPTH = WIDTH * HEIGHT;

    // One extra bit so the limit is representable even when
    // DEPTH == 2**ADDR_W; the compare stays unsigned.
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Swap handshake state
    // ------------------------------------------------------------------
    logic front_bank_r;
    logic pending_r;
    logic swapped_r;
    logic overrun_r;
    logic back_bank;
    logic clr_busy_w;
    logic do_swap;

    assign back_bank = ~front_bank_r;

    // A frame arriving in the same cycle as swap_req counts as pending.
    assign do_swap = bus.swap_req && (pending_r || bus.frame_done) && !clr_busy_w;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a read or write in the
    // swap cycle see the old bank assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_bank_r <= 1'b0;
            pending_r    <= 1'b0;
            swapped_r    <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            swapped_r <= do_swap;
            overrun_r <= bus.frame_done && pending_r;
            if (do_swap) begin
                front_bank_r <= ~front_bank_r;
                pending_r    <= 1'b0;
            end else if (bus.frame_done) begin
                pending_r    <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    logic              clr_write;
    logic              clr_tgt;
    logic [ADDR_W-1:0] clr_cnt;

`ifdef NES_FB_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t        clr_state;
    logic              clr_tgt_r;
    logic [ADDR_W-1:0] clr_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Abandons a fill in progress; whatever was written stays.
            clr_state <= IDLE;
            clr_tgt_r <= 1'b0;
            clr_cnt_r <= '0;
        end else begin
            case (clr_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        clr_state <= CLEAR;
                        clr_tgt_r <= back_bank;
                        clr_cnt_r <= '0;
                    end
                end
                CLEAR: begin
                    // A PPU write owns the bank write port this cycle;
                    // the fill pauses and resumes at the same address.
                    if (!bus.wr_en) begin
                        if (clr_cnt_r == LAST) begin
                            clr_state <= IDLE;
                        end else begin
                            clr_cnt_r <= clr_cnt_r + 1'b1;
                        end
                    end
                end
                default: clr_state <= IDLE;
            endcase
        end
    end

    assign clr_busy_w = (clr_state == CLEAR);
    assign clr_write  = clr_busy_w;
    assign clr_tgt    = clr_tgt_r;
    assign clr_cnt    = clr_cnt_r;
`else
    assign clr_busy_w = 1'b0;
    assign clr_write  = 1'b0;
    assign clr_tgt    = 1'b0;
    assign clr_cnt    = '0;
`endif

    // ------------------------------------------------------------------
    // Shared write port: PPU first, then the clear engine
    // ------------------------------------------------------------------
    logic              wr_in_range;
    logic [1:0]        mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [PIX_W-1:0]  mem_wd;

    assign wr_in_range = {1'b0, bus.wr_addr} < LIMIT;

    // NOTE: every output of this block gets a default before any branch so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mem_we = 2'b00;
        mem_wa = bus.wr_addr;
        mem_wd = bus.wr_data;
        if (bus.wr_en) begin
            if (wr_in_range) begin
                mem_we[back_bank] = 1'b1;
            end
        end else if (clr_write) begin
            mem_we[clr_tgt] = 1'b1;
            mem_wa          = clr_cnt;
            mem_wd          = CLEAR_VAL;
        end
    end

    // ------------------------------------------------------------------
    // Bank storage: one write port, one registered read port each
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];
    logic [PIX_W-1:0] q0;
    logic [PIX_W-1:0] q1;

    // NOTE: the arrays and their read registers have no reset so they map
    // onto block RAM; a reset loop over 61440 entries would force flops.
    always_ff @(posedge clk) begin
        if (mem_we[0]) begin
            mem0[mem_wa] <= mem_wd;
        end
        if (bus.rd_en) begin
            q0 <= mem0[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we[1]) begin
            mem1[mem_wa] <= mem_wd;
        end
        if (bus.rd_en) begin
            q1 <= mem1[bus.rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Read path control
    // ------------------------------------------------------------------
    // Bank select and range flag are captured alongside the address, so the
    // output is a pure select between registers and holds while rd_en=0.
    // Reset forces the range flag, which makes rd_data read back as 0.
    logic rd_valid_r;
    logic rd_sel_r;
    logic rd_oob_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_sel_r   <= 1'b0;
            rd_oob_r   <= 1'b1;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_r <= front_bank_r;
                rd_oob_r <= !({1'b0, bus.rd_addr} < LIMIT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_data    = rd_oob_r ? '0 : (rd_sel_r ? q1 : q0);
    assign bus.rd_valid   = rd_valid_r;
    assign bus.swapped    = swapped_r;
    assign bus.overrun    = overrun_r;
    assign bus.pending    = pending_r;
    assign bus.front_bank = front_bank_r;
    assign bus.clr_busy   = clr_busy_w;

endmodule

// File: tb/tb_nes_fb_dbuf.sv
// ----------------------------------------------------------------------------
// tb_nes_fb_dbuf
//   Directed bench for nes_fb_dbuf at default parameters. Inputs change 1 ns
//   after the rising edge and outputs are sampled at that same point, i.e.
//   after the edge that consumed the previous input vector. Clear-engine
//   scenarios are compiled only with NES_FB_CLEAR_EN.
// ----------------------------------------------------------------------------
module tb_nes_fb_dbuf;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    nes_fb_dbuf_if #(.ADDR_W(16), .PIX_W(6)) bus ();

    nes_fb_dbuf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [5:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [5:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_valid"}, bus.rd_valid, 1);
        check(tag, bus.rd_data, exp);
    endtask

    task automatic pulse_frame_done();
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
    endtask

    task automatic pulse_swap_req();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;
        bus.swap_req   = 1'b0;
        bus.clr_req    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        check("rst_front",    bus.front_bank, 0);
        check("rst_pending",  bus.pending,    0);
        check("rst_rd_valid", bus.rd_valid,   0);
        check("rst_rd_data",  bus.rd_data,    0);
        check("rst_swapped",  bus.swapped,    0);
        check("rst_overrun",  bus.overrun,    0);
        check("rst_clr_busy", bus.clr_busy,   0);

        // ---------------- read latency ----------------
        bus.rd_en   = 1'b1;
        bus.rd_addr = 16'd0;
        tick();
        bus.rd_en   = 1'b0;
        check("rd0_valid", bus.rd_valid, 1);
        tick();
        check("rd_idle_valid", bus.rd_valid, 0);

        // ---------------- basic write / frame_done / swap ----------------
        wr(16'd100, 6'h2A);                  // lands in bank 1 (back)
        pulse_frame_done();
        check("fd_pending", bus.pending, 1);
        check("fd_front",   bus.front_bank, 0);
        pulse_swap_req();
        check("sw1_swapped", bus.swapped,    1);
        check("sw1_front",   bus.front_bank, 1);
        check("sw1_pending", bus.pending,    0);
        tick();
        check("sw1_swapped_clr", bus.swapped, 0);
        wr(16'd100, 6'h15);                  // now bank 0 is back
        rd_chk("rd100_bank1", 16'd100, 6'h2A);

        // ---------------- overrun and ignored swap ----------------
        pulse_frame_done();
        check("ov_first_pending", bus.pending, 1);
        check("ov_first_overrun", bus.overrun, 0);
        pulse_frame_done();
        check("ov_second_overrun", bus.overrun, 1);
        check("ov_second_pending", bus.pending, 1);
        tick();
        check("ov_pulse_end", bus.overrun, 0);
        pulse_swap_req();
        check("sw2_front",   bus.front_bank, 0);
        check("sw2_swapped", bus.swapped,    1);
        check("sw2_pending", bus.pending,    0);
        pulse_swap_req();
        check("sw_ignored_front",   bus.front_bank, 0);
        check("sw_ignored_swapped", bus.swapped,    0);
        rd_chk("rd100_bank0", 16'd100, 6'h15);

        // ---------------- same-cycle frame_done + swap_req ----------------
        bus.frame_done = 1'b1;
        bus.swap_req   = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 16'd200;
        bus.wr_data    = 6'h33;
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 16'd100;
        tick();
        bus.frame_done = 1'b0;
        bus.swap_req   = 1'b0;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        check("same_front",   bus.front_bank, 1);
        check("same_pending", bus.pending,    0);
        check("same_swapped", bus.swapped,    1);
        check("same_overrun", bus.overrun,    0);
        check("same_rd_old_bank", bus.rd_data, 6'h15);
        rd_chk("rd200_old_back", 16'd200, 6'h33);

        // ---------------- address boundaries ----------------
        wr(16'd61439, 6'h2B);                // bank 0 (back), last valid
        wr(16'd61440, 6'h3F);                // out of range, dropped
        pulse_frame_done();
        pulse_swap_req();
        check("bnd_front", bus.front_bank, 0);
        rd_chk("rd_last",  16'd61439, 6'h2B);
        rd_chk("rd_oob",   16'd61440, 6'h00);
        rd_chk("rd_last2", 16'd61439, 6'h2B);
        rd_chk("rd_max",   16'd65535, 6'h00);
        rd_chk("rd_last3", 16'd61439, 6'h2B);
        tick();
        check("hold_valid", bus.rd_valid, 0);
        check("hold_data",  bus.rd_data,  6'h2B);

`ifdef NES_FB_CLEAR_EN
        // ---------------- clear with PPU writes and deferred swap ----------------
        begin
            int n;
            bus.clr_req = 1'b1;
            tick();
            bus.clr_req = 1'b0;
            check("clr_start_busy", bus.clr_busy, 1);
            n = 0;
            while (bus.clr_busy && n < 70000) begin
                bus.frame_done = (n == 100);
                bus.swap_req   = (n == 200);
                bus.clr_req    = (n == 300);
                bus.wr_en      = (n >= 1000 && n < 1010);
                bus.wr_addr    = 16'(500 + n - 1000);
                bus.wr_data    = 6'(32 + n - 1000);
                tick();
                n++;
                if (n == 201) begin
                    check("defer_front",   bus.front_bank, 0);
                    check("defer_pending", bus.pending,    1);
                    check("defer_swapped", bus.swapped,    0);
                end
            end
            bus.frame_done = 1'b0;
            bus.swap_req   = 1'b0;
            bus.clr_req    = 1'b0;
            bus.wr_en      = 1'b0;
            check("clr_cycles", n, 61450);
            check("clr_pending_after", bus.pending, 1);
            pulse_swap_req();
            check("clr_swap_swapped", bus.swapped,    1);
            check("clr_swap_front",   bus.front_bank, 1);
            rd_chk("clr_rd0",     16'd0,     6'h0F);
            rd_chk("clr_rd100",   16'd100,   6'h0F);
            rd_chk("clr_rd200",   16'd200,   6'h0F);
            rd_chk("clr_rd499",   16'd499,   6'h0F);
            rd_chk("clr_ppu500",  16'd500,   6'h20);
            rd_chk("clr_ppu505",  16'd505,   6'h25);
            rd_chk("clr_ppu509",  16'd509,   6'h29);
            rd_chk("clr_rd510",   16'd510,   6'h0F);
            rd_chk("clr_rd61439", 16'd61439, 6'h0F);
        end

        // ---------------- reset mid-clear ----------------
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("rstclr_busy_on", bus.clr_busy, 1);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstclr_busy_off", bus.clr_busy,   0);
        check("rstclr_front",    bus.front_bank, 0);
`else
        // ---------------- clear engine absent ----------------
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("noclr_busy", bus.clr_busy, 0);
        pulse_frame_done();
        pulse_swap_req();
        check("noclr_swap", bus.front_bank, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
